// File: rtl/tiled_mult_seq_if.sv
// Operand/product handshake bundle for tiled_mult_seq.
// Optional macro TILED_MULT_SIGNED_EN adds the is_signed operand qualifier.
interface tiled_mult_seq_if #(
  parameter int WIDTH = 32
);
  // Valid/ready semantics on both sides: a transfer happens on a rising clock
  // edge where valid && ready. Once valid is raised, the producer holds the
  // payload stable until that edge. ready may depend on state only, never on valid.
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;
`ifdef TILED_MULT_SIGNED_EN
  logic               is_signed;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );
  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
`endif
endinterface

// File: rtl/tiled_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier built from one TILE x TILE multiplier, one partial product per clock.
// Optional macro TILED_MULT_SIGNED_EN enables two's complement operands via bus.is_signed.
module tiled_mult_seq #(
  parameter int WIDTH = 32,
  parameter int TILE  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tiled_mult_seq_if.slave     bus,
  output logic [1:0]          state_dbg
);

  localparam int N  = WIDTH / TILE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [CW-1:0]        i_q, j_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [TILE-1:0]      a_tile, b_tile;
  logic [2*TILE-1:0]    pp;
  logic [2*WIDTH-1:0]   pp_shifted;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 accept;
  logic                 i_last;
  logic                 last_tile;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign i_last    = (i_q == CW'(N - 1));
  assign last_tile = i_last && (j_q == CW'(N - 1));

  assign a_tile     = a_q[int'(i_q)*TILE +: TILE];
  assign b_tile     = b_q[int'(j_q)*TILE +: TILE];
  assign pp         = {{TILE{1'b0}}, a_tile} * {{TILE{1'b0}}, b_tile};
  assign pp_shifted = (2*WIDTH)'(pp) << ((int'(i_q) + int'(j_q)) * TILE);

`ifdef TILED_MULT_SIGNED_EN
  logic sign_q;

  // Signed mode multiplies magnitudes; -MIN still fits as an unsigned WIDTH value.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign bus.product = sign_q ? -acc_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (accept) begin
      sign_q <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end
  end
`else
  assign a_mag       = bus.a;
  assign b_mag       = bus.b;
  assign bus.product = acc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (last_tile) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= a_mag;
      b_q   <= b_mag;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_q + pp_shifted;
      // i walks A tiles fastest; j advances once per full sweep of i.
      if (i_last) begin
        i_q <= '0;
        j_q <= last_tile ? '0 : j_q + CW'(1);
      end else begin
        i_q <= i_q + CW'(1);
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_tiled_mult_seq.sv
// Directed bench for tiled_mult_seq: latency/handshake model with per-cycle compare plus literal products.
module tb_tiled_mult_seq;

  localparam int W  = 32;
  localparam int T  = 8;
  localparam int NN = (W / T) * (W / T);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tiled_mult_seq_if #(.WIDTH(W)) ifc ();
  logic [1:0] state_dbg;

  tiled_mult_seq #(.WIDTH(W), .TILE(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .state_dbg (state_dbg)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*W-1:0] exp_q[$];

  // Model: 0 = waiting for operands, 1 = computing, 2 = holding a result.
  int m_phase = 0;
  int m_cnt   = 0;
  bit chk_en  = 1'b0;

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic sgn);
    logic [2*W-1:0] xe, ye;
    xe = sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = sgn ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic sgn;
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      exp_q.delete();
    end else begin
`ifdef TILED_MULT_SIGNED_EN
      sgn = ifc.is_signed;
`else
      sgn = 1'b0;
`endif
      case (m_phase)
        0: if (ifc.in_valid) begin
             exp_q.push_back(ref_product(ifc.a, ifc.b, sgn));
             m_phase = 1;
             m_cnt   = 0;
           end
        1: begin
             m_cnt++;
             if (m_cnt == NN) m_phase = 2;
           end
        default: if (ifc.out_ready) begin
             void'(exp_q.pop_front());
             m_phase = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  {63'd0, ifc.in_ready},  {63'd0, m_phase == 0});
      check("busy",      {63'd0, ifc.busy},      {63'd0, m_phase == 1});
      check("out_valid", {63'd0, ifc.out_valid}, {63'd0, m_phase == 2});
      if (m_phase == 2) begin
        if (exp_q.size() == 0) check("model_queue", 64'd1, 64'd0);
        else check("product_model", ifc.product, exp_q[0]);
      end
    end
  end

  // Enters with in_ready stable; returns at the negedge after the output handshake.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sgn,
                         input int hold, input bit keep, input logic [2*W-1:0] lit,
                         input string nm);
    int n_wait;
    int lat;
    ifc.a        = ta;
    ifc.b        = tb_v;
    ifc.in_valid = 1'b1;
`ifdef TILED_MULT_SIGNED_EN
    ifc.is_signed = sgn;
`endif
    n_wait = 0;
    while (!ifc.in_ready && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    if (!ifc.in_ready) begin
      check({nm, "_accept_timeout"}, 64'd0, 64'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) ifc.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ifc.out_valid && lat < 100);
    check({nm, "_latency"}, 64'(lat), 64'(NN));
    check({nm, "_product"}, ifc.product, lit);
    if (hold > 0) begin
      ifc.in_valid = 1'b1;
      ifc.a        = 32'hDEAD_BEEF;
      ifc.b        = 32'h1234_5678;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        @(negedge clk);
        check({nm, "_hold_product"}, ifc.product, lit);
        check({nm, "_hold_in_ready"}, {63'd0, ifc.in_ready}, 64'd0);
      end
      ifc.in_valid = 1'b0;
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    check({nm, "_post_in_ready"},  {63'd0, ifc.in_ready},  64'd1);
    check({nm, "_post_out_valid"}, {63'd0, ifc.out_valid}, 64'd0);
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.out_ready = 1'b0;
`ifdef TILED_MULT_SIGNED_EN
    ifc.is_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {63'd0, ifc.in_ready},  64'd1);
    check("reset_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    check("reset_busy",      {63'd0, ifc.busy},      64'd0);
    check("reset_product",   ifc.product,            64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    run_txn(32'd3, 32'd5, 1'b0, 0, 1'b0, 64'h0000_0000_0000_000F, "t1_3x5");
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 64'hFFFF_FFFE_0000_0001, "t2_max");
    run_txn(32'h0001_0000, 32'h0001_0000, 1'b0, 5, 1'b0, 64'h0000_0001_0000_0000, "t3_stall");
    run_txn(32'hFFFF_0000, 32'h0000_0002, 1'b0, 0, 1'b1, 64'h0000_0001_FFFE_0000, "t4_b2b_a");
    run_txn(32'h0000_0007, 32'h0000_0009, 1'b0, 0, 1'b0, 64'h0000_0000_0000_003F, "t4_b2b_b");
    run_txn(32'h0000_0000, 32'h1234_5678, 1'b0, 0, 1'b0, 64'h0000_0000_0000_0000, "t5_zero");

    // Abort a computation partway through BUSY.
    ifc.a        = 32'h0123_4567;
    ifc.b        = 32'h89AB_CDEF;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    check("abort_busy",      {63'd0, ifc.busy},      64'd0);
    check("abort_product",   ifc.product,            64'd0);
    check("abort_in_ready",  {63'd0, ifc.in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(32'd2, 32'd2, 1'b0, 0, 1'b0, 64'd4, "t6_after_abort");

`ifdef TILED_MULT_SIGNED_EN
    run_txn(32'hFFFF_FFFE, 32'd3, 1'b1, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, "t7_neg2x3");
    run_txn(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0, 64'h4000_0000_0000_0000, "t7_minxmin");
    run_txn(32'hFFFF_FFFE, 32'd3, 1'b0, 0, 1'b0, 64'h0000_0002_FFFF_FFFA, "t7_unsigned");
`endif

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before %0t", $time);
    $fatal(1);
  end

endmodule
